// File: rtl/fetch_stall_controller.sv
// Fetch-side stall consumer: PC, imem request handshake, IF/ID register and skid.
// Optional stall-cycle counter is built when FETCH_STALL_PERF_EN is defined.
module fetch_stall_controller #(
    parameter int                        BUS_DATA_WIDTH = 64,
    parameter int                        INS_WIDTH      = 32,
    parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      inPCWrite,
    input  logic                      inIfIdWrite,
    input  logic                      inCtrlMux,
    input  logic                      inBranchTaken,
    input  logic [BUS_DATA_WIDTH-1:0] inBranchTarget,
    output logic                      outFetchReq,
    output logic [BUS_DATA_WIDTH-1:0] outFetchAddr,
    input  logic                      inFetchValid,
    input  logic [INS_WIDTH-1:0]      inFetchData,
    output logic [BUS_DATA_WIDTH-1:0] outPC,
    output logic [INS_WIDTH-1:0]      outIns,
    output logic                      outInsValid,
    output logic                      outIdExBubble,
    output logic [31:0]               outStallCount
);

    localparam logic [INS_WIDTH-1:0] NOP = INS_WIDTH'(32'h00000013);
    localparam logic [BUS_DATA_WIDTH-1:0] STEP = BUS_DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t                    state;
    logic [BUS_DATA_WIDTH-1:0] pc;
    logic [BUS_DATA_WIDTH-1:0] pc_next;
    logic [INS_WIDTH-1:0]      skid_data;
    logic [BUS_DATA_WIDTH-1:0] skid_addr;
    logic                      skid_valid;

    assign pc_next       = pc + STEP;
    assign outIdExBubble = inCtrlMux;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            outFetchReq  <= 1'b0;
            outFetchAddr <= '0;
            outPC        <= '0;
            outIns       <= NOP;
            outInsValid  <= 1'b0;
            skid_data    <= NOP;
            skid_addr    <= '0;
            skid_valid   <= 1'b0;
        end else begin
            outFetchReq <= 1'b0;
            if (inBranchTaken) begin
                pc          <= inBranchTarget;
                outIns      <= NOP;
                outInsValid <= 1'b0;
                skid_valid  <= 1'b0;
                case (state)
                    S_WAIT, S_DISCARD: begin
                        // A response this cycle retires the old fetch, so refetch now
                        if (inFetchValid) begin
                            outFetchReq  <= 1'b1;
                            outFetchAddr <= inBranchTarget;
                            state        <= S_WAIT;
                        end else begin
                            state <= S_DISCARD;
                        end
                    end
                    S_HOLD: begin
                        outFetchReq  <= 1'b1;
                        outFetchAddr <= inBranchTarget;
                        state        <= S_WAIT;
                    end
                    default: state <= S_IDLE;
                endcase
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (inIfIdWrite) begin
                            outIns      <= NOP;
                            outInsValid <= 1'b0;
                        end
                        if (inPCWrite) begin
                            outFetchReq  <= 1'b1;
                            outFetchAddr <= pc;
                            state        <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (inFetchValid) begin
                            if (inIfIdWrite) begin
                                outIns      <= inFetchData;
                                outPC       <= pc;
                                outInsValid <= 1'b1;
                                if (inPCWrite) begin
                                    pc           <= pc_next;
                                    outFetchReq  <= 1'b1;
                                    outFetchAddr <= pc_next;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end else begin
                                skid_data  <= inFetchData;
                                skid_addr  <= pc;
                                skid_valid <= 1'b1;
                                state      <= S_HOLD;
                            end
                        end else if (inIfIdWrite) begin
                            outIns      <= NOP;
                            outInsValid <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (inIfIdWrite) begin
                            outIns      <= skid_data;
                            outPC       <= skid_addr;
                            outInsValid <= skid_valid;
                            skid_valid  <= 1'b0;
                            if (inPCWrite) begin
                                pc           <= pc_next;
                                outFetchReq  <= 1'b1;
                                outFetchAddr <= pc_next;
                                state        <= S_WAIT;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_DISCARD: begin
                        if (inIfIdWrite) begin
                            outIns      <= NOP;
                            outInsValid <= 1'b0;
                        end
                        if (inFetchValid) begin
                            outFetchReq  <= 1'b1;
                            outFetchAddr <= pc;
                            state        <= S_WAIT;
                        end
                    end
                endcase
            end
        end
    end

`ifdef FETCH_STALL_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!inIfIdWrite && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign outStallCount = stall_cnt;
`else
    assign outStallCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stall_controller.sv
// Vector/scoreboard bench for fetch_stall_controller, incl. wrap and mid-run reset.
module tb_fetch_stall_controller;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset_n;
    logic        pcw;
    logic        ifid;
    logic        mux;
    logic        br;
    logic [63:0] tgt;
    logic        fv;
    logic [31:0] fdata;

    logic        req;
    logic [63:0] addr;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        ins_valid;
    logic        bubble;
    logic [31:0] stall_cnt;

    logic        req2;
    logic [63:0] addr2;
    logic [63:0] pc2;
    logic [31:0] ins2;
    logic        ins_valid2;
    logic        bubble2;
    logic [31:0] stall_cnt2;

    fetch_stall_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .inPCWrite     (pcw),
        .inIfIdWrite   (ifid),
        .inCtrlMux     (mux),
        .inBranchTaken (br),
        .inBranchTarget(tgt),
        .outFetchReq   (req),
        .outFetchAddr  (addr),
        .inFetchValid  (fv),
        .inFetchData   (fdata),
        .outPC         (pc),
        .outIns        (ins),
        .outInsValid   (ins_valid),
        .outIdExBubble (bubble),
        .outStallCount (stall_cnt)
    );

    fetch_stall_controller #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .reset_n       (reset_n),
        .inPCWrite     (pcw),
        .inIfIdWrite   (ifid),
        .inCtrlMux     (mux),
        .inBranchTaken (br),
        .inBranchTarget(tgt),
        .outFetchReq   (req2),
        .outFetchAddr  (addr2),
        .inFetchValid  (fv),
        .inFetchData   (fdata),
        .outPC         (pc2),
        .outIns        (ins2),
        .outInsValid   (ins_valid2),
        .outIdExBubble (bubble2),
        .outStallCount (stall_cnt2)
    );

    typedef struct {
        logic        req;
        logic [63:0] addr;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        valid;
        logic        chk2;
        logic [63:0] addr2;
        logic [31:0] sc;
    } exp_t;

    typedef struct {
        logic        pcw;
        logic        ifid;
        logic        mux;
        logic        br;
        logic [63:0] tgt;
        logic        fv;
        logic [31:0] fdata;
        exp_t        e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   sc_model = 0;
    int   step_no = 0;
    exp_t exp_q[$];
    vec_t vecs[23];
    vec_t rvecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic p, input logic w, input logic m, input logic b,
        input logic [63:0] t, input logic v, input logic [31:0] d,
        input logic er, input logic [63:0] ea, input logic [63:0] ep,
        input logic [31:0] ei, input logic ev
    );
        vec_t r;
        r.pcw = p; r.ifid = w; r.mux = m; r.br = b;
        r.tgt = t; r.fv = v; r.fdata = d;
        r.e.req = er; r.e.addr = ea; r.e.pc = ep;
        r.e.ins = ei; r.e.valid = ev;
        r.e.chk2 = 1'b0; r.e.addr2 = '0; r.e.sc = '0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h",
                     step_no, nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_sc();
`ifdef FETCH_STALL_PERF_EN
        return 32'(sc_model);
`else
        return 32'd0;
`endif
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        pcw = v.pcw; ifid = v.ifid; mux = v.mux; br = v.br;
        tgt = v.tgt; fv = v.fv; fdata = v.fdata;
        if (!v.ifid) sc_model++;
        e = v.e;
        e.sc = exp_sc();
        exp_q.push_back(e);
        #1 chk("bubble", {63'd0, bubble}, {63'd0, v.mux});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("req", {63'd0, req}, {63'd0, e.req});
        chk("addr", addr, e.addr);
        chk("pc", pc, e.pc);
        chk("ins", {32'd0, ins}, {32'd0, e.ins});
        chk("valid", {63'd0, ins_valid}, {63'd0, e.valid});
        chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, e.sc});
        if (e.chk2) begin
            chk("wrap_req", {63'd0, req2}, 64'd1);
            chk("wrap_addr", addr2, e.addr2);
        end
        step_no++;
    endtask

    task automatic chk_reset();
        chk("rst_req", {63'd0, req}, 64'd0);
        chk("rst_addr", addr, 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_ins", {32'd0, ins}, {32'd0, NOP});
        chk("rst_valid", {63'd0, ins_valid}, 64'd0);
        chk("rst_stall", {32'd0, stall_cnt}, 64'd0);
        chk("rst_wrap_addr", addr2, 64'd0);
    endtask

    initial begin
        vecs[0]  = mk(1,1,0,0,64'h0,  0,32'h0,        1,64'h0,  64'h0,  NOP,0);
        vecs[1]  = mk(1,1,0,0,64'h0,  1,32'h00A00093, 1,64'h4,  64'h0,  32'h00A00093,1);
        vecs[2]  = mk(0,0,1,0,64'h0,  1,32'h00100113, 0,64'h4,  64'h0,  32'h00A00093,1);
        vecs[3]  = mk(1,1,0,0,64'h0,  0,32'h0,        1,64'h8,  64'h4,  32'h00100113,1);
        vecs[4]  = mk(1,1,0,1,64'h100,0,32'h0,        0,64'h8,  64'h4,  NOP,0);
        vecs[5]  = mk(1,1,0,0,64'h0,  0,32'h0,        0,64'h8,  64'h4,  NOP,0);
        vecs[6]  = mk(1,1,0,0,64'h0,  1,32'hDEADBEEF, 1,64'h100,64'h4,  NOP,0);
        vecs[7]  = mk(1,1,0,0,64'h0,  1,32'h00000513, 1,64'h104,64'h100,32'h00000513,1);
        vecs[8]  = mk(0,0,0,1,64'h200,0,32'h0,        0,64'h104,64'h100,NOP,0);
        vecs[9]  = mk(0,0,0,0,64'h0,  1,32'h11111111, 1,64'h200,64'h100,NOP,0);
        vecs[10] = mk(0,1,0,0,64'h0,  1,32'h00000593, 0,64'h200,64'h200,32'h00000593,1);
        vecs[11] = mk(0,0,0,0,64'h0,  1,32'hCAFEF00D, 0,64'h200,64'h200,32'h00000593,1);
        vecs[12] = mk(1,1,0,0,64'h0,  0,32'h0,        1,64'h200,64'h200,NOP,0);
        vecs[13] = mk(1,1,0,0,64'h0,  0,32'h0,        0,64'h200,64'h200,NOP,0);
        vecs[14] = mk(1,1,0,0,64'h0,  1,32'h00000613, 1,64'h204,64'h200,32'h00000613,1);
        vecs[15] = mk(1,0,0,0,64'h0,  0,32'h0,        0,64'h204,64'h200,32'h00000613,1);
        vecs[16] = mk(1,1,0,0,64'h0,  0,32'h0,        0,64'h204,64'h200,NOP,0);
        vecs[17] = mk(1,1,0,0,64'h0,  1,32'h00000693, 1,64'h208,64'h204,32'h00000693,1);
        vecs[18] = mk(1,1,0,1,64'h300,1,32'h77777777, 1,64'h300,64'h204,NOP,0);
        vecs[19] = mk(0,0,0,0,64'h0,  1,32'h00000713, 0,64'h300,64'h204,NOP,0);
        vecs[20] = mk(0,0,0,1,64'h400,0,32'h0,        1,64'h400,64'h204,NOP,0);
        vecs[21] = mk(0,1,0,0,64'h0,  1,32'h00000793, 0,64'h400,64'h400,32'h00000793,1);
        vecs[22] = mk(1,1,0,0,64'h0,  0,32'h0,        1,64'h400,64'h400,NOP,0);
        vecs[0].e.chk2 = 1'b1;
        vecs[0].e.addr2 = 64'hFFFF_FFFF_FFFF_FFFC;
        vecs[1].e.chk2 = 1'b1;
        vecs[1].e.addr2 = 64'h0;

        rvecs[0] = mk(0,1,0,0,64'h0,0+1,32'h12345678, 0,64'h0,64'h0,NOP,0);
        rvecs[1] = mk(1,1,0,0,64'h0,0,32'h0,          1,64'h0,64'h0,NOP,0);
        for (int i = 2; i < 7; i++)
            rvecs[i] = mk(0,0,0,0,64'h0,0,32'h0,      0,64'h0,64'h0,NOP,0);
        rvecs[7] = mk(1,1,0,0,64'h0,1,32'h00A00093,   1,64'h4,64'h0,32'h00A00093,1);

        reset_n = 1'b0;
        pcw = 0; ifid = 0; mux = 0; br = 0; tgt = '0; fv = 0; fdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset();
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) step(vecs[i]);

        // Reset asserted mid-cycle while a fetch is outstanding
        reset_n = 1'b0;
        sc_model = 0;
        #1 chk_reset();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) step(rvecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
